// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared constants, state encoding and helpers for the signed divider
package div_pkg;

  localparam int WIDTH = 32;
  localparam int ITERS = 32;
  localparam int CNT_W = $clog2(ITERS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Unsigned magnitude of a two's-complement value; the most negative value maps to itself.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

endpackage

// File: rtl/div_addsub.sv
// rtl/div_addsub.sv - add/subtract unit for the divider partial remainder
module div_addsub #(
  parameter int W = 33
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] y
);

  assign y = sub ? (a - b) : (a + b);

endmodule

// File: rtl/div_32bit.sv
// rtl/div_32bit.sv - 33-cycle signed radix-2 divider, remainder in z[63:32], quotient in z[31:0]
module div_32bit #(
  parameter int WIDTH = div_pkg::WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   Q,
  input  logic [WIDTH-1:0]   M,
  output logic [2*WIDTH-1:0] z,
  output logic               busy,
  output logic               done,
  output logic               div_zero
);

  import div_pkg::*;

  state_t state, nxt;

  logic [WIDTH-1:0] q_lat;
  logic [WIDTH-1:0] m_mag;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic             sign_q;
  logic             sign_m;
  logic             m_zero;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] quo_s;
  logic [WIDTH-1:0] rem_s;

  // Restoring step: shift the next dividend bit in, keep the difference when it is non-negative.
  assign shifted = {rem, quo[WIDTH-1]};

  div_addsub #(
    .W(WIDTH + 1)
  ) u_addsub (
    .a  (shifted),
    .b  ({1'b0, m_mag}),
    .sub(1'b1),
    .y  (diff)
  );

  assign quo_s = (sign_q ^ sign_m) ? -quo : quo;
  assign rem_s = sign_q ? -rem : rem;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = RUN;
      RUN:     if (cnt == CNT_W'(ITERS - 1)) nxt = FIX;
      FIX:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      q_lat    <= '0;
      m_mag    <= '0;
      quo      <= '0;
      rem      <= '0;
      sign_q   <= 1'b0;
      sign_m   <= 1'b0;
      m_zero   <= 1'b0;
      cnt      <= '0;
      z        <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            q_lat  <= Q;
            sign_q <= Q[WIDTH-1];
            sign_m <= M[WIDTH-1];
            m_zero <= (M == '0);
            quo    <= mag(Q);
            m_mag  <= mag(M);
            rem    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (!diff[WIDTH]) begin
            rem <= diff[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= shifted[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
        end
        FIX: begin
          busy     <= 1'b0;
          done     <= 1'b1;
          div_zero <= m_zero;
          // Divide-by-zero returns the dividend as remainder and an all-ones quotient.
          if (m_zero) z <= {q_lat, {WIDTH{1'b1}}};
          else        z <= {rem_s, quo_s};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_32bit.sv
// tb/tb_div_32bit.sv - self-checking bench for div_32bit
module tb_div_32bit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] Q;
  logic [31:0] M;
  logic [63:0] z;
  logic        busy;
  logic        done;
  logic        div_zero;

  int errors = 0;
  int checks = 0;

  div_32bit #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .Q       (Q),
    .M       (M),
    .z       (z),
    .busy    (busy),
    .done    (done),
    .div_zero(div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: signed division on 64-bit integers, truncated back to 32 bits.
  function automatic logic [64:0] model(input logic [31:0] q, input logic [31:0] m);
    longint a, b, qu, re;
    if (m == 32'd0) return {1'b1, q, 32'hFFFFFFFF};
    a  = longint'($signed(q));
    b  = longint'($signed(m));
    qu = a / b;
    re = a % b;
    return {1'b0, re[31:0], qu[31:0]};
  endfunction

  // Called at posedge+1 with the DUT idle; returns at posedge+1 in the done cycle.
  task automatic run_op(input string tag, input logic [31:0] q, input logic [31:0] m,
                        input logic [63:0] exp_z, input logic exp_dz);
    int cyc;
    start = 1'b1;
    Q     = q;
    M     = m;
    @(posedge clk); #1;
    check({tag, " busy_accept"}, 64'(busy), 64'd1);
    start = 1'b0;
    Q     = $urandom;
    M     = $urandom;
    cyc   = 1;
    while (cyc <= 40) begin
      @(posedge clk); #1;
      if (done) break;
      if (cyc == 5) begin
        start = 1'b1;
        Q     = $urandom;
        M     = $urandom;
      end
      if (cyc == 8) start = 1'b0;
      cyc++;
    end
    check({tag, " latency"}, 64'(cyc), 64'd33);
    check({tag, " z"}, z, exp_z);
    check({tag, " div_zero"}, 64'(div_zero), 64'(exp_dz));
    check({tag, " busy_done"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic [64:0] r;
    logic [31:0] rq, rm;
    logic [63:0] held;
    int          seen;

    rst   = 1'b0;
    start = 1'b0;
    Q     = 32'd0;
    M     = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset z", z, 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset div_zero", 64'(div_zero), 64'd0);

    rst = 1'b1;
    run_op("q1m2", 32'd1, 32'd2, 64'h00000001_00000000, 1'b0);
    held = z;
    @(posedge clk); #1;
    check("done_pulse_len", 64'(done), 64'd0);
    check("z_hold", z, held);

    run_op("q2m4", 32'd2, 32'd4, 64'h00000002_00000000, 1'b0);
    run_op("q100m7", 32'd100, 32'd7, 64'h00000002_0000000E, 1'b0);
    run_op("qm7m2", 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 1'b0);
    run_op("q5m0", 32'd5, 32'd0, 64'h00000005_FFFFFFFF, 1'b1);
    held = z;
    repeat (3) @(posedge clk);
    #1;
    check("div_zero_hold", 64'(div_zero), 64'd1);
    check("z_hold_dz", z, held);
    run_op("min_m1", 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0);
    run_op("m7_m2", 32'hFFFFFFF9, 32'hFFFFFFFE, 64'hFFFFFFFF_00000003, 1'b0);

    for (int i = 0; i < 24; i++) begin
      rq = $urandom;
      case (i % 4)
        0:       rm = $urandom;
        1:       rm = $urandom_range(1, 15);
        2:       rm = -($urandom_range(1, 15));
        default: rm = (i == 3) ? 32'd0 : $urandom_range(0, 1000) - 500;
      endcase
      r = model(rq, rm);
      run_op($sformatf("rand%0d", i), rq, rm, r[63:0], r[64]);
    end

    start = 1'b1;
    Q     = 32'd1000;
    M     = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort z", z, 64'd0);
    check("abort busy", 64'(busy), 64'd0);
    check("abort done", 64'(done), 64'd0);
    rst  = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    check("abort no_done", 64'(seen), 64'd0);
    run_op("after_abort", 32'd1000, 32'd3, 64'h00000001_0000014D, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div_32bit.md
DIV_32BIT -- requirements
Module: div_32bit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand width; only 32 SHALL be supported.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit; reset is synchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit, a request to begin a division, sampled only while idle.
REQ-005 The block SHALL have port Q, input, 32 bits, the dividend (signed two's complement).
REQ-006 The block SHALL have port M, input, 32 bits, the divisor (signed two's complement).
REQ-007 The block SHALL have port z, output, 64 bits: z[63:32] is the remainder and z[31:0] is the quotient.
REQ-008 The block SHALL have port busy, output, 1 bit, high from the accepting edge until done.
REQ-009 The block SHALL have port done, output, 1 bit, a one-cycle pulse when z is updated.
REQ-010 The block SHALL have port div_zero, output, 1 bit, high with z when the result came from M=0.

Function
REQ-011 The block SHALL have states IDLE, RUN and FIX; IDLE->RUN on start; RUN->FIX after 32 iterations; FIX->IDLE after one cycle.
REQ-012 When start=1 in IDLE at edge N, the block SHALL latch Q and M, and busy SHALL go high after edge N.
REQ-013 RUN SHALL perform one radix-2 shift/subtract iteration per cycle on the operand magnitudes, over edges N+1..N+32.
REQ-014 At edge N+33 (FIX), the block SHALL apply sign correction and write z; done SHALL be high for exactly that following cycle, and busy SHALL drop at the same time.
REQ-015 The quotient SHALL truncate toward zero, and the remainder SHALL take the sign of the dividend, so that Q = quotient*M + remainder.
REQ-016 M=0 SHALL give remainder=Q, quotient=0xFFFFFFFF and div_zero=1, with the same 33-cycle latency.
REQ-017 Q=0x80000000 with M=0xFFFFFFFF SHALL give quotient 0x80000000 and remainder 0, with no flag.
REQ-018 start while busy SHALL be ignored; operand changes after the accepting edge SHALL not affect the result.
REQ-019 z and div_zero SHALL hold their values until the next FIX cycle writes them.
REQ-020 start asserted in the done cycle SHALL be accepted, because the block is then IDLE, giving back-to-back operations every 34 cycles.
REQ-021 Latency SHALL be fixed at 33 cycles regardless of operand values.

Reset
REQ-022 While rst=0 at a clock edge, the block SHALL enter IDLE and clear z=0, busy=0, done=0, div_zero=0 and all internal registers.
REQ-023 Reset during RUN or FIX SHALL abort the operation, and no done pulse SHALL follow.
REQ-024 The first start SHALL be honoured on the first edge with rst=1.

Structure
REQ-025 Package div_pkg SHALL hold WIDTH, the iteration count (32) and the state enumeration.
REQ-026 A single sub-module div_addsub SHALL implement the 33-bit add/subtract of the partial remainder, and the top level SHALL contain the FSM, counter, sign handling and output registers.

Verification
REQ-027 Q=1, M=2, start -> done 33 cycles later, z=0x00000001_00000000, div_zero=0.
REQ-028 Q=2, M=4 -> z=0x00000002_00000000; then Q=100, M=7 -> z=0x00000002_0000000E.
REQ-029 Q=0xFFFFFFF9 (-7), M=2 -> z=0xFFFFFFFF_FFFFFFFD (remainder -1, quotient -3).
REQ-030 Q=5, M=0 -> z=0x00000005_FFFFFFFF, div_zero=1.
REQ-031 Q=0x80000000, M=0xFFFFFFFF -> z=0x00000000_80000000.
REQ-032 Start, then rst=0 at cycle 10 -> z=0, busy=0, no done; a start issued after reset completes normally, and a start during busy is ignored.
